// File: rtl/led_text_pkg.sv
// Shared constants and character mapping for the scrolling LED text engine.
package led_text_pkg;
   localparam logic [7:0]  CHAR_BASE   = 8'h20;
   localparam logic [7:0]  CHAR_MAX    = 8'h7F;
   localparam int unsigned FONT_ADDR_W = 10;
   localparam int unsigned COL_W       = 3;
   localparam int unsigned CHAR_IDX_W  = 7;

   typedef logic [COL_W-1:0]      col_t;
   typedef logic [CHAR_IDX_W-1:0] char_idx_t;

   // Bytes outside the printable range fall back to the space glyph.
   function automatic char_idx_t char_idx(input logic [7:0] c);
      char_idx_t idx;
      idx = '0;
      if (c >= CHAR_BASE && c <= CHAR_MAX) idx = char_idx_t'(c - CHAR_BASE);
      return idx;
   endfunction
endpackage

// File: rtl/tick_divider.sv
// Column-rate divider: one-clock tick every DIV_COEF+1 enabled clocks.
module tick_divider #(
   parameter logic [31:0] DIV_COEF = 32'd5000
) (
   input  logic clk_in,
   input  logic nrst,
   input  logic en,
   output logic tick
);
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == DIV_COEF) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/led_text_engine.sv
// Scrolling text engine: walks a message column by column, drives an external
// synchronous font ROM and presents the bit-reversed glyph column on the LEDs.
module led_text_engine
   import led_text_pkg::*;
#(
   parameter logic [31:0] DIV_COEF = 32'd5000,
   parameter int unsigned MSG_LEN  = 16,
   parameter int unsigned COLS     = 6,
   parameter int unsigned LED_W    = 8
) (
   input  logic                       clk_in,
   input  logic                       nrst,
   input  logic                       en,
   input  logic                       dir,
   input  logic                       wr_en,
   input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
   input  logic [7:0]                 wr_data,
   output logic [FONT_ADDR_W-1:0]     font_addr,
   input  logic [LED_W-1:0]           font_data,
   output logic [LED_W-1:0]           led,
   output logic                       frame_done
);
   localparam int unsigned POS_W = $clog2(MSG_LEN);

   logic                   tick, col_wrap;
   col_t                   col_q, col_d, rd_col;
   logic [POS_W-1:0]       pos_q, pos_d, rd_pos;
   logic                   dir_q, dir_d;
   logic                   frame_done_q, frame_done_d;
   logic                   en_p1_q, en_p2_q;
   logic [FONT_ADDR_W-1:0] font_addr_q, font_addr_d;
   logic [LED_W-1:0]       led_q, led_d;
   logic [7:0]             msg_q [MSG_LEN];

   tick_divider #(.DIV_COEF(DIV_COEF)) u_div (
      .clk_in (clk_in),
      .nrst   (nrst),
      .en     (en),
      .tick   (tick)
   );

   always_comb begin
      col_wrap     = tick && (col_q == col_t'(COLS - 1));
      col_d        = col_q;
      pos_d        = pos_q;
      if (tick) col_d = col_wrap ? '0 : col_q + col_t'(1);
      if (col_wrap) pos_d = pos_q + POS_W'(1);
      frame_done_d = col_wrap && (pos_q == POS_W'(MSG_LEN - 1));
      // Direction only changes between characters so a glyph is never torn.
      dir_d        = (!en || col_wrap) ? dir : dir_q;
      rd_pos       = dir_q ? POS_W'(MSG_LEN - 1) - pos_q : pos_q;
      rd_col       = dir_q ? col_t'(COLS - 1) - col_q : col_q;
      font_addr_d  = {char_idx(msg_q[rd_pos]), rd_col};
      led_d        = '0;
      for (int unsigned i = 0; i < LED_W; i++) led_d[i] = font_data[LED_W-1-i];
      if (!en_p2_q) led_d = '0;
   end

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         col_q        <= '0;
         pos_q        <= '0;
         dir_q        <= 1'b0;
         frame_done_q <= 1'b0;
         en_p1_q      <= 1'b0;
         en_p2_q      <= 1'b0;
         font_addr_q  <= '0;
         led_q        <= '0;
      end else begin
         col_q        <= col_d;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         frame_done_q <= frame_done_d;
         en_p1_q      <= en;
         en_p2_q      <= en_p1_q;
         font_addr_q  <= font_addr_d;
         led_q        <= led_d;
      end
   end

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= CHAR_BASE;
      end else if (wr_en) begin
         msg_q[wr_addr] <= wr_data;
      end
   end

   assign font_addr  = font_addr_q;
   assign led        = led_q;
   assign frame_done = frame_done_q;
endmodule
